// File: rtl/side_probe_sequencer_pkg.sv
// Shared state encoding, result codes and default timing for the side-probe sequencer.
// Purely declarative: no latency, no flow control.
package side_probe_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_TURN,
        ST_CLEAR,
        ST_DONE
    } state_e;

    localparam logic [1:0] RES_STRAIGHT = 2'b00;
    localparam logic [1:0] RES_LEFT     = 2'b01;
    localparam logic [1:0] RES_RIGHT    = 2'b10;
    localparam logic [1:0] RES_AROUND   = 2'b11;

    localparam int CNT_W          = 16;
    localparam int DEF_WIN_MS     = 1000;
    localparam int DEF_TURN90_MS  = 900;
    localparam int DEF_CLEAR_MS   = 1000;
    localparam int DEF_TIMEOUT_MS = 5000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stable_window_counter.sv
// Counts consecutive ticks on which sig matched its previous tick sample; saturating.
// Count/reached update one cycle after the tick; no backpressure, clear has priority over tick.
// sample exposes the value captured on the most recent tick.
module stable_window_counter
    import side_probe_sequencer_pkg::*;
#(
    parameter int LIMIT = DEF_WIN_MS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             clear,
    input  logic             sig,
    output logic [CNT_W-1:0] count,
    output logic             reached,
    output logic             sample
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sample_q, sample_d;

    // First tick after clear always yields 1: either a match from 0 or a reload.
    always_comb begin
        count_d  = count_q;
        sample_d = sample_q;
        if (clear) begin
            count_d  = '0;
            sample_d = 1'b0;
        end else if (tick) begin
            sample_d = sig;
            count_d  = (sig == sample_q) ? sat_inc(count_q) : CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            sample_q <= sample_d;
        end
    end

    assign count   = count_q;
    assign reached = (count_q >= LIM);
    assign sample  = sample_q;

endmodule

// File: rtl/side_probe_sequencer.sv
// Self-check sequencer: probe side detectors, turn toward the free side, confirm the front clears.
// All outputs registered; decisions act one cycle after the deciding tick. No backpressure; abort wins.
module side_probe_sequencer
    import side_probe_sequencer_pkg::*;
#(
    parameter int WIN_MS     = DEF_WIN_MS,
    parameter int TURN90_MS  = DEF_TURN90_MS,
    parameter int CLEAR_MS   = DEF_CLEAR_MS,
    parameter int TIMEOUT_MS = DEF_TIMEOUT_MS
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       start,
    input  logic       abort,
    input  logic       front_detector,
    input  logic       left_detector,
    input  logic       right_detector,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic       fail,
    output logic       turn_left,
    output logic       turn_right
);

    localparam logic [CNT_W-1:0] TURN1  = CNT_W'(TURN90_MS);
    localparam logic [CNT_W-1:0] TURN2  = CNT_W'(2 * TURN90_MS);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_MS);

    state_e           state_q, state_d;
    logic [1:0]       result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic             tl_q, tl_d, tr_q, tr_d;
    logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d, to_cnt_q, to_cnt_d, turn_next;
    logic             dec_l_q, dec_l_d, dec_r_q, dec_r_d;
    logic             val_l_q, val_l_d, val_r_q, val_r_d;

    logic             side_tick, side_clr, front_tick, front_clr;
    logic             l_reached, r_reached, f_reached, l_sample, r_sample, f_sample;
    logic [CNT_W-1:0] l_count, r_count, f_count;
    logic             l_known, r_known, l_val, r_val;
    logic             unused_obs;

    assign side_tick  = tick_ms && (state_q == ST_PROBE);
    assign side_clr   = (state_q != ST_PROBE);
    assign front_tick = tick_ms && (state_q == ST_CLEAR);
    assign front_clr  = (state_q != ST_CLEAR) || front_detector;
    assign unused_obs = ^{l_count, r_count, f_count, f_sample};

    stable_window_counter #(.LIMIT(WIN_MS)) u_left (
        .clk(sys_clk), .rst_n(rst), .tick(side_tick), .clear(side_clr), .sig(left_detector),
        .count(l_count), .reached(l_reached), .sample(l_sample)
    );

    stable_window_counter #(.LIMIT(WIN_MS)) u_right (
        .clk(sys_clk), .rst_n(rst), .tick(side_tick), .clear(side_clr), .sig(right_detector),
        .count(r_count), .reached(r_reached), .sample(r_sample)
    );

    // Held in clear while the front is blocked, so it only ever counts free ticks.
    stable_window_counter #(.LIMIT(CLEAR_MS)) u_front (
        .clk(sys_clk), .rst_n(rst), .tick(front_tick), .clear(front_clr), .sig(front_detector),
        .count(f_count), .reached(f_reached), .sample(f_sample)
    );

    assign l_known = dec_l_q || l_reached;
    assign r_known = dec_r_q || r_reached;
    assign l_val   = dec_l_q ? val_l_q : l_sample;
    assign r_val   = dec_r_q ? val_r_q : r_sample;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fail_d     = 1'b0;
        tl_d       = tl_q;
        tr_d       = tr_q;
        turn_cnt_d = turn_cnt_q;
        to_cnt_d   = to_cnt_q;
        dec_l_d    = dec_l_q;
        dec_r_d    = dec_r_q;
        val_l_d    = val_l_q;
        val_r_d    = val_r_q;
        turn_next  = sat_inc(turn_cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_PROBE;
                    busy_d     = 1'b1;
                    turn_cnt_d = '0;
                    to_cnt_d   = '0;
                    dec_l_d    = 1'b0;
                    dec_r_d    = 1'b0;
                end
            end
            ST_PROBE: begin
                if (l_reached && !dec_l_q) begin
                    dec_l_d = 1'b1;
                    val_l_d = l_sample;
                end
                if (r_reached && !dec_r_q) begin
                    dec_r_d = 1'b1;
                    val_r_d = r_sample;
                end
                if (l_known && r_known) begin
                    result_d   = {l_val, r_val};
                    turn_cnt_d = '0;
                    if ({l_val, r_val} == RES_STRAIGHT) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_TURN;
                        tl_d    = ({l_val, r_val} != RES_RIGHT);
                        tr_d    = ({l_val, r_val} == RES_RIGHT);
                    end
                end
            end
            ST_TURN: begin
                if (tick_ms) begin
                    turn_cnt_d = turn_next;
                    if (turn_next >= ((result_q == RES_AROUND) ? TURN2 : TURN1)) begin
                        state_d  = ST_CLEAR;
                        tl_d     = 1'b0;
                        tr_d     = 1'b0;
                        to_cnt_d = '0;
                    end
                end
            end
            ST_CLEAR: begin
                if (tick_ms) begin
                    to_cnt_d = sat_inc(to_cnt_q);
                end
                if (f_reached) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (to_cnt_q >= TO_LIM) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            fail_d   = 1'b0;
            tl_d     = 1'b0;
            tr_d     = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            result_q   <= RES_STRAIGHT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            tl_q       <= 1'b0;
            tr_q       <= 1'b0;
            turn_cnt_q <= '0;
            to_cnt_q   <= '0;
            dec_l_q    <= 1'b0;
            dec_r_q    <= 1'b0;
            val_l_q    <= 1'b0;
            val_r_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            tl_q       <= tl_d;
            tr_q       <= tr_d;
            turn_cnt_q <= turn_cnt_d;
            to_cnt_q   <= to_cnt_d;
            dec_l_q    <= dec_l_d;
            dec_r_q    <= dec_r_d;
            val_l_q    <= val_l_d;
            val_r_q    <= val_r_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign result     = result_q;
    assign turn_left  = tl_q;
    assign turn_right = tr_q;

endmodule

// File: tb/tb_side_probe_sequencer.sv
// Bench for side_probe_sequencer: directed scenarios plus random detector traces against a tick-level model.
module tb_side_probe_sequencer;

    localparam int WIN     = 4;
    localparam int TURN90  = 3;
    localparam int CLEARMS = 2;
    localparam int TIMEOUT = 10;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_ms = 1'b0, start = 1'b0, abort = 1'b0;
    logic       front_detector = 1'b0, left_detector = 1'b0, right_detector = 1'b0;
    logic       busy, done, fail, turn_left, turn_right;
    logic [1:0] result;

    int checks = 0;
    int errors = 0;

    int tick_total = 0, tl_total = 0, tr_total = 0, done_total = 0;
    int fail_total = 0, busy_total = 0, both_total = 0, done_tick_abs = 0;

    side_probe_sequencer #(
        .WIN_MS(WIN), .TURN90_MS(TURN90), .CLEAR_MS(CLEARMS), .TIMEOUT_MS(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .tick_ms(tick_ms), .start(start), .abort(abort),
        .front_detector(front_detector), .left_detector(left_detector),
        .right_detector(right_detector), .busy(busy), .done(done), .result(result),
        .fail(fail), .turn_left(turn_left), .turn_right(turn_right)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (tick_ms) begin
            tick_total = tick_total + 1;
            if (turn_left)  tl_total = tl_total + 1;
            if (turn_right) tr_total = tr_total + 1;
        end
        if (done) begin
            done_total    = done_total + 1;
            done_tick_abs = tick_total;
        end
        if (fail) fail_total = fail_total + 1;
        if (busy) busy_total = busy_total + 1;
        if (turn_left && turn_right) both_total = both_total + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A side is decided at the first tick where its trailing run of equal samples reaches WIN.
    function automatic void decide(input logic [63:0] s, output int dt, output logic v);
        int run;
        run = 0;
        dt  = 0;
        v   = 1'b0;
        for (int t = 1; t < 64; t++) begin
            run = (t > 1 && s[t] == s[t-1]) ? run + 1 : 1;
            if (dt == 0 && run >= WIN) begin
                dt = t;
                v  = s[t];
            end
        end
    endfunction

    // Tick-indexed outcome of one run: sample bit t is the detector value at tick t after start.
    function automatic void model(input logic [63:0] l, r, f, output logic [1:0] res,
                                  output int tl, output int tr, output int dtick, output bit fl);
        int dl, dr, d, z, t;
        logic vl, vr;
        decide(l, dl, vl);
        decide(r, dr, vr);
        d     = (dl > dr) ? dl : dr;
        res   = {vl, vr};
        tl    = (res == 2'b01) ? TURN90 : (res == 2'b11) ? 2 * TURN90 : 0;
        tr    = (res == 2'b10) ? TURN90 : 0;
        dtick = 0;
        fl    = 1'b0;
        if (res == 2'b00) begin
            dtick = d;
        end else begin
            z = 0;
            for (int k = 1; k <= TIMEOUT; k++) begin
                t = d + tl + tr + k;
                if (dtick == 0) begin
                    z = f[t] ? 0 : z + 1;
                    if (z >= CLEARMS) begin
                        dtick = t;
                    end else if (k == TIMEOUT) begin
                        dtick = t;
                        fl    = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic do_run(input string tag, input logic [63:0] l, r, f, input bit extra,
                          output int obs_dtick, output logic [1:0] obs_res);
        logic [1:0] m_res;
        int m_tl, m_tr, m_dt;
        bit m_fl, seen;
        int tk0, tl0, tr0, dn0, fl0;
        model(l, r, f, m_res, m_tl, m_tr, m_dt, m_fl);
        tk0 = tick_total; tl0 = tl_total; tr0 = tr_total; dn0 = done_total; fl0 = fail_total;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        seen = 1'b0;
        for (int t = 1; t <= 40 && !seen; t++) begin
            left_detector  = l[t];
            right_detector = r[t];
            front_detector = f[t];
            tick_ms = 1'b1;
            cyc(1);
            tick_ms = 1'b0;
            cyc(3);
            if (extra && t == 2) begin
                start = 1'b1;
                cyc(1);
                start = 1'b0;
            end
            seen = (done_total != dn0);
        end
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        cyc(2);
        obs_dtick = done_tick_abs - tk0;
        obs_res   = result;
        chk({tag, ".result"}, 32'(result), 32'(m_res));
        chk({tag, ".turn_left_ticks"}, 32'(tl_total - tl0), 32'(m_tl));
        chk({tag, ".turn_right_ticks"}, 32'(tr_total - tr0), 32'(m_tr));
        chk({tag, ".done_cycles"}, 32'(done_total - dn0), 32'd1);
        chk({tag, ".fail_cycles"}, 32'(fail_total - fl0), 32'(m_fl));
        chk({tag, ".done_tick"}, 32'(obs_dtick), 32'(m_dt));
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dt;
        logic [1:0] rs;
        int dn0, bz0;
        logic [63:0] l, r, f;
        logic lc, rc;
        int n;

        cyc(2);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.fail", 32'(fail), 32'd0);
        chk("reset.result", 32'(result), 32'd0);
        chk("reset.turns", 32'({turn_left, turn_right}), 32'd0);
        rst = 1'b1;
        cyc(2);

        do_run("left", 64'd0, '1, 64'd0, 1'b0, dt, rs);
        chk("left.done_tick_const", 32'(dt), 32'd9);
        do_run("around", '1, '1, 64'd0, 1'b0, dt, rs);
        chk("around.done_tick_const", 32'(dt), 32'd12);
        do_run("straight", 64'd0, 64'd0, 64'd0, 1'b0, dt, rs);
        chk("straight.done_tick_const", 32'(dt), 32'd4);
        do_run("toggle", 64'd0, 64'hFFFF_FFFF_FFFF_FFD5, 64'd0, 1'b0, dt, rs);
        chk("toggle.done_tick_const", 32'(dt), 32'd14);
        do_run("timeout", 64'd0, '1, '1, 1'b0, dt, rs);
        chk("timeout.done_tick_const", 32'(dt), 32'd17);

        // Abort while turning left.
        dn0 = done_total;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        left_detector = 1'b0;
        right_detector = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick_ms = 1'b1;
            cyc(1);
            tick_ms = 1'b0;
            cyc(3);
        end
        chk("abort.turning_before", 32'(turn_left), 32'd1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.turns", 32'({turn_left, turn_right}), 32'd0);
        chk("abort.result_kept", 32'(result), 32'(2'b01));
        cyc(4);
        chk("abort.no_done", 32'(done_total - dn0), 32'd0);

        // start and abort together from IDLE.
        bz0 = busy_total;
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        cyc(4);
        chk("start_abort.busy_cycles", 32'(busy_total - bz0), 32'd0);
        chk("start_abort.no_done", 32'(done_total - dn0), 32'd0);
        chk("start_abort.result_kept", 32'(result), 32'(2'b01));

        // Reset mid-run clears result; next start is accepted.
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            tick_ms = 1'b1;
            cyc(1);
            tick_ms = 1'b0;
            cyc(3);
        end
        chk("midrst.busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #3;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.result", 32'(result), 32'd0);
        chk("midrst.turns", 32'({turn_left, turn_right}), 32'd0);
        cyc(1);
        rst = 1'b1;
        cyc(2);
        do_run("after_rst", 64'd0, '1, 64'd0, 1'b0, dt, rs);

        for (int i = 0; i < 12; i++) begin
            n  = $urandom_range(0, 6);
            lc = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            for (int t = 0; t < 64; t++) begin
                l[t] = (t <= n) ? 1'($urandom_range(0, 1)) : lc;
                r[t] = (t <= n) ? 1'($urandom_range(0, 1)) : rc;
                f[t] = ($urandom_range(0, 3) == 0);
            end
            do_run($sformatf("rand%0d", i), l, r, f, 1'($urandom_range(0, 1)), dt, rs);
        end

        chk("never_both_turns", 32'(both_total), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
